// File: rtl/gf_ops_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_ops_pkg : shared state and mode encodings for the GF datapath   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gf_ops_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic GF_MODE  = 1'b1;
   localparam logic INT_MODE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_BUSY = BUSY,
      ST_DONE = DONE
   } state_e;

endpackage : gf_ops_pkg
`default_nettype wire

// File: rtl/gf_rca_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_rca_adder : ripple-carry adder, carry chain suppressed in GF    |
// | mode so the sum degenerates to XOR.  Rev 1.0                       |
// +--------------------------------------------------------------------+
module gf_rca_adder
   import gf_ops_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  gf_option_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] sum_o,
   output logic                  co_o
);

   logic                w_int_mode;
   logic [DATA_WIDTH:0] w_carry;

   assign w_int_mode = (gf_option_i == INT_MODE);
   assign w_carry[0] = 1'b0;

   generate
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
         assign sum_o[i]     = a_i[i] ^ b_i[i] ^ w_carry[i];
         assign w_carry[i+1] = w_int_mode &
                               ((a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i])));
      end
   endgenerate

   assign co_o = w_carry[DATA_WIDTH];

endmodule : gf_rca_adder
`default_nettype wire

// File: rtl/gf_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_seq_multiplier : shift-and-add multiplier, one multiplier bit   |
// | per cycle, carry-less or integer product.  Rev 1.0                 |
// +--------------------------------------------------------------------+
module gf_seq_multiplier
   import gf_ops_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    gf_option,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] product,
   output logic                    out_gf
);

   localparam int             CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

   state_e                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [DATA_WIDTH-1:0]   m_q;
   logic [DATA_WIDTH-1:0]   phi_q;
   logic [DATA_WIDTH-1:0]   plo_q;
   logic                    mode_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic [2*DATA_WIDTH-1:0] product_q;
   logic                    out_gf_q;

   logic [DATA_WIDTH-1:0]   w_add_sum;
   logic                    w_add_co;
   logic [DATA_WIDTH-1:0]   w_acc_s;
   logic                    w_acc_c;
   logic [DATA_WIDTH-1:0]   phi_d;
   logic [DATA_WIDTH-1:0]   plo_d;

   gf_rca_adder #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_acc_adder (
      .gf_option_i (mode_q),
      .a_i         (phi_q),
      .b_i         (m_q),
      .sum_o       (w_add_sum),
      .co_o        (w_add_co)
   );

   // The adder already kills its carry chain in GF mode; masking co here as
   // well keeps the shifted-in MSB clean even if a different adder is swapped in.
   always_comb begin
      w_acc_s        = plo_q[0] ? w_add_sum : phi_q;
      w_acc_c        = plo_q[0] & w_add_co & (mode_q != GF_MODE);
      {phi_d, plo_d} = {w_acc_c, w_acc_s, plo_q[DATA_WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         m_q         <= '0;
         phi_q       <= '0;
         plo_q       <= '0;
         mode_q      <= INT_MODE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         product_q   <= '0;
         out_gf_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  m_q        <= a;
                  plo_q      <= b;
                  phi_q      <= '0;
                  mode_q     <= gf_option;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               phi_q <= phi_d;
               plo_q <= plo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  product_q   <= {phi_d, plo_d};
                  out_gf_q    <= mode_q;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  product_q   <= '0;
                  out_gf_q    <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               product_q   <= '0;
               out_gf_q    <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign out_gf    = out_gf_q;

endmodule : gf_seq_multiplier
`default_nettype wire

// File: tb/tb_gf_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gf_seq_multiplier : directed scoreboard bench, W=8 and W=32     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_gf_seq_multiplier;

   typedef struct packed {
      logic        gf;
      logic [63:0] p;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv8, ir8, gfo8, ov8, or8, og8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv32, ir32, gfo32, ov32, or32, og32;
   logic [31:0] a32, b32;
   logic [63:0] p32;

   int   n_err = 0;
   int   n_chk = 0;
   exp_t sbq[$];

   gf_seq_multiplier #(.DATA_WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .gf_option(gfo8),
      .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(p8), .out_gf(og8)
   );

   gf_seq_multiplier #(.DATA_WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .gf_option(gfo32),
      .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .product(p32), .out_gf(og32)
   );

   function automatic logic [63:0] model(int w, logic [31:0] x, logic [31:0] y, logic g);
      logic [63:0] acc = '0;
      logic [63:0] xe  = {32'd0, x};
      for (int i = 0; i < w; i++)
         if (y[i]) acc = g ? (acc ^ (xe << i)) : (acc + (xe << i));
      return acc;
   endfunction

   function automatic logic obs_ir(int s); return (s == 0) ? ir8 : ir32; endfunction
   function automatic logic obs_ov(int s); return (s == 0) ? ov8 : ov32; endfunction
   function automatic logic obs_og(int s); return (s == 0) ? og8 : og32; endfunction
   function automatic logic [63:0] obs_p(int s); return (s == 0) ? {48'd0, p8} : p32; endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(int s, logic v, logic [31:0] x, logic [31:0] y, logic g);
      if (s == 0) begin iv8 = v; a8 = x[7:0]; b8 = y[7:0]; gfo8 = g; end
      else        begin iv32 = v; a32 = x; b32 = y; gfo32 = g; end
   endtask

   task automatic set_or(int s, logic r);
      if (s == 0) or8 = r; else or32 = r;
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic issue(int s, logic [31:0] x, logic [31:0] y, logic g);
      int w = (s == 0) ? 8 : 32;
      set_in(s, 1'b1, x, y, g);
      chk("in_ready_idle", {63'd0, obs_ir(s)}, 64'd1);
      sbq.push_back('{gf: g, p: model(w, x, y, g)});
      @(negedge clk);
      set_in(s, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic wait_done(int s, int n0, string tag, output exp_t e);
      int w = (s == 0) ? 8 : 32;
      int n = n0;
      e = '0;
      while (!obs_ov(s) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(w));
      if (obs_ov(s) && sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, "_product"}, obs_p(s), e.p);
         chk({tag, "_out_gf"}, {63'd0, obs_og(s)}, {63'd0, e.gf});
         chk({tag, "_in_ready_done"}, {63'd0, obs_ir(s)}, 64'd0);
      end
   endtask

   task automatic release_out(int s, string tag);
      set_or(s, 1'b1);
      @(negedge clk);
      set_or(s, 1'b0);
      chk({tag, "_ov_after"}, {63'd0, obs_ov(s)}, 64'd0);
      chk({tag, "_ir_after"}, {63'd0, obs_ir(s)}, 64'd1);
      chk({tag, "_p_after"}, obs_p(s), 64'd0);
   endtask

   initial begin
      exp_t e;
      set_in(0, 1'b0, 32'd0, 32'd0, 1'b0);
      set_in(1, 1'b0, 32'd0, 32'd0, 1'b0);
      or8 = 1'b0;
      or32 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         chk("rst_in_ready", {63'd0, obs_ir(s)}, 64'd1);
         chk("rst_out_valid", {63'd0, obs_ov(s)}, 64'd0);
         chk("rst_product", obs_p(s), 64'd0);
         chk("rst_out_gf", {63'd0, obs_og(s)}, 64'd0);
      end

      issue(0, 32'h57, 32'h83, 1'b0);  wait_done(0, 0, "int_57x83", e); release_out(0, "int_57x83");
      chk("int_57x83_const", e.p, 64'h2C85);
      issue(0, 32'h57, 32'h83, 1'b1);  wait_done(0, 0, "gf_57x83", e);  release_out(0, "gf_57x83");
      chk("gf_57x83_const", e.p, 64'h2B79);
      issue(0, 32'hFF, 32'hFF, 1'b0);  wait_done(0, 0, "int_ffxff", e); release_out(0, "int_ffxff");
      issue(0, 32'hFF, 32'hFF, 1'b1);  wait_done(0, 0, "gf_ffxff", e);  release_out(0, "gf_ffxff");
      issue(0, 32'h00, 32'hFF, 1'b0);  wait_done(0, 0, "int_0xff", e);  release_out(0, "int_0xff");
      issue(0, 32'h00, 32'hFF, 1'b1);  wait_done(0, 0, "gf_0xff", e);   release_out(0, "gf_0xff");
      issue(0, 32'hA5, 32'h01, 1'b0);  wait_done(0, 0, "int_bone", e);  release_out(0, "int_bone");
      issue(0, 32'hA5, 32'h01, 1'b1);  wait_done(0, 0, "gf_bone", e);   release_out(0, "gf_bone");
      issue(0, 32'hC3, 32'h00, 1'b1);  wait_done(0, 0, "gf_bzero", e);  release_out(0, "gf_bzero");

      // Inputs wiggle during BUSY and DONE; the latched operation must not move.
      issue(0, 32'h57, 32'h83, 1'b1);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1'b1, $urandom, $urandom, 1'(i));
         @(negedge clk);
      end
      set_in(0, 1'b0, 32'd0, 32'd0, 1'b0);
      wait_done(0, 3, "hold", e);
      for (int i = 0; i < 5; i++) begin
         set_in(0, 1'(i), $urandom, $urandom, 1'(~i));
         @(negedge clk);
         chk("hold_product", obs_p(0), e.p);
         chk("hold_out_valid", {63'd0, ov8}, 64'd1);
         chk("hold_in_ready", {63'd0, ir8}, 64'd0);
         chk("hold_out_gf", {63'd0, og8}, 64'd1);
      end
      set_in(0, 1'b0, 32'd0, 32'd0, 1'b0);
      release_out(0, "hold");

      // Reset during BUSY aborts; the queued expectation is dropped.
      issue(0, 32'h12, 32'h34, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sbq.pop_back());
      chk("abort_out_valid", {63'd0, ov8}, 64'd0);
      chk("abort_product", obs_p(0), 64'd0);
      chk("abort_in_ready", {63'd0, ir8}, 64'd1);
      issue(0, 32'h03, 32'h05, 1'b1);  wait_done(0, 0, "gf_3x5", e);    release_out(0, "gf_3x5");
      chk("gf_3x5_const", e.p, 64'h000F);

      // W=32: in_valid held high, second request follows the first release.
      set_in(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("b2b_in_ready", {63'd0, ir32}, 64'd1);
      sbq.push_back('{gf: 1'b0, p: model(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0)});
      @(negedge clk);
      set_in(1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
      wait_done(1, 0, "w32_int_max", e);
      chk("w32_int_max_const", e.p, 64'hFFFF_FFFE_0000_0001);
      set_or(1, 1'b1);
      @(negedge clk);
      set_or(1, 1'b0);
      chk("b2b_ir_after_release", {63'd0, ir32}, 64'd1);
      sbq.push_back('{gf: 1'b1, p: model(32, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1)});
      @(negedge clk);
      set_in(1, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("b2b_second_accepted", {63'd0, ir32}, 64'd0);
      wait_done(1, 0, "w32_gf_second", e);
      release_out(1, "w32_gf_second");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_gf_seq_multiplier
`default_nettype wire

// File: doc/gf_seq_multiplier.md
Name: gf_seq_multiplier

Overview:
- Iterative shift-and-add multiplier; one multiplier bit per cycle.
- gf_option=1: carry-less (GF(2)[x]) unreduced polynomial product. gf_option=0: unsigned integer product.
- Sits directly downstream of gf_rca_adder and instantiates it as the accumulation adder.
- Feeds the later GF(2^m) reduction stage and integer datapaths through a valid/ready result port.

Parameters:
- DATA_WIDTH, 32, operand width W. Product is 2W. Legal W >= 2.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Synchronous active-high reset.
- in_valid  input  1  Operand request.
- in_ready  output  1  Block can accept operands; high only in IDLE.
- gf_option  input  1  Mode: 1 = carry-less, 0 = integer. Sampled at acceptance.
- a  input  W  Multiplicand.
- b  input  W  Multiplier.
- out_valid  output  1  Product valid.
- out_ready  input  1  Consumer accepts product.
- product  output  2W  Result.
- out_gf  output  1  Mode latched for this product.

Behaviour:
- Reset: one clock, synchronous active-high; rst sampled high on a rising edge.
  - State becomes IDLE; counter 0; out_valid 0; product 0; out_gf 0.
  - in_ready is 1 in the cycle after reset.
  - Reset mid-BUSY or in DONE aborts the operation; the result is discarded.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Handshake on in_valid & in_ready:
    - M <= a; P_lo <= b; P_hi <= 0; mode <= gf_option; cnt <= 0; go to BUSY.
  - BUSY: in_ready=0. Each cycle:
    - If P_lo[0]=1: {c,s} = gf_rca_adder(mode, P_hi, M). Otherwise c=0, s=P_hi.
    - {P_hi, P_lo} <= {c, s, P_lo[W-1:1]}.
    - cnt increments. When cnt = W-1, go to DONE.
  - DONE: out_valid=1; product = {P_hi, P_lo}; out_gf = mode.
    - Hold product, out_gf and out_valid stable until out_ready=1, then go to IDLE.
- Latency: handshake on edge t0 → out_valid high after edge t0+W (exactly W BUSY cycles).
  - Minimum issue interval: W+2 cycles. No overlap of operations.
- Carry rule: in GF mode c is forced to 0 regardless of the adder's co.
  - Integer mode uses co as the carry into P_hi's MSB after the shift.
  - Integer result = a*b exactly; no overflow is possible in 2W bits.
- Inputs (a, b, gf_option, in_valid) are ignored outside IDLE.
- product reads 0 outside DONE; out_valid=0 outside DONE.
- out_ready while not in DONE has no effect.
- Operand edge cases: a=0 or b=0 → product 0. b=1 → product {0, a}. Both modes behave identically for these.

Decomposition:
- Shared package gf_ops_pkg:
  - State encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Mode constants GF_MODE=1'b1, INT_MODE=1'b0.
- Sub-module: the existing gf_rca_adder (DATA_WIDTH=W), single instance for accumulation.
- Counter width: $clog2(W).

Test Plan:
- W=8, int, a=0x57, b=0x83 → product 0x2C85, out_gf=0, out_valid exactly 8 cycles after handshake.
- W=8, gf, a=0x57, b=0x83 → product 0x2B79, out_gf=1.
- W=8, a=b=0xFF, both modes → int 0xFE01; gf 0x5555. Also a=0, b=0xFF → 0x0000 in both modes.
- W=8, out_ready held low 5 cycles in DONE → product, out_valid and in_ready=0 stable throughout.
  - Toggle a, b and in_valid during BUSY/DONE → result unchanged.
  - out_ready=1 → IDLE next cycle, in_ready=1.
- W=8, assert rst at BUSY cycle 3 → next cycle IDLE, out_valid=0, product=0.
  - New request a=0x03, b=0x05, gf → product 0x000F.
- W=32, int, a=b=0xFFFFFFFF → product 0xFFFFFFFE00000001 after 32 cycles.
  - Back-to-back requests with in_valid held high → second accepted the cycle after first out_ready.
